a_io_l3_in_serialize_a_m_axi_read_throttle: RTL and testbench

//  Read-direction counterpart of the m_axi write throttle: sits between the kernel-side (TOP) AR/R channels and the
//  AXI bus (BUS). Issues an AR burst only when the internal R data buffer has reserved room for every beat of it and

---
 rtl/a_io_l3_in_serialize_a_m_axi_read_throttle.sv | 168 ++++++++++++++++
 tb/tb_a_io_l3_in_serialize_a_m_axi_read_throttle.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a_io_l3_in_serialize_a_m_axi_read_throttle.sv
`default_nettype none
// ============================================================================
// Module : a_io_l3_in_serialize_a_m_axi_read_throttle
// Brief  : AXI read throttle. Forwards a kernel AR burst to the bus only when
//          the local R buffer has room reserved for every beat of it and the
//          number of outstanding bursts is below MAXREQS. Bus R beats are
//          therefore always accepted and replayed to the kernel in order.
// Rev    : 1.0  initial release
// ============================================================================
module a_io_l3_in_serialize_a_m_axi_read_throttle #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int MAXREQS    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic [ADDR_WIDTH-1:0] in_TOP_ARADDR,
  input  logic [7:0]            in_TOP_ARLEN,
  input  logic                  in_TOP_ARVALID,
  output logic                  out_TOP_ARREADY,
  output logic [DATA_WIDTH-1:0] out_TOP_RDATA,
  output logic                  out_TOP_RLAST,
  output logic                  out_TOP_RVALID,
  input  logic                  in_TOP_RREADY,
  output logic [ADDR_WIDTH-1:0] out_BUS_ARADDR,
  output logic [7:0]            out_BUS_ARLEN,
  output logic                  out_BUS_ARVALID,
  input  logic                  in_BUS_ARREADY,
  input  logic [DATA_WIDTH-1:0] in_BUS_RDATA,
  input  logic                  in_BUS_RLAST,
  input  logic                  in_BUS_RVALID,
  output logic                  out_BUS_RREADY
);

  localparam int c_AW = $clog2(DEPTH);        // FIFO pointer width
  localparam int c_OW = $clog2(MAXREQS) + 1;  // outstanding counter width
  localparam int c_FW = c_AW + 9;             // fit arithmetic width, safe for ARLEN=255
  localparam int c_EW = DATA_WIDTH + 1;       // FIFO entry {last,data}

  localparam logic [c_FW-1:0] c_DEPTH_F = c_FW'(DEPTH);
  localparam logic [c_AW:0]   c_DEPTH_C = (c_AW + 1)'(DEPTH);
  localparam logic [c_OW-1:0] c_MAXREQS = c_OW'(MAXREQS);

  // AR holding register
  logic                  r_ar_valid;
  logic [ADDR_WIDTH-1:0] r_ar_addr;
  logic [7:0]            r_ar_len;

  // Reservation and outstanding-burst bookkeeping
  logic [c_AW:0]         r_rsv;
  logic [c_OW-1:0]       r_outs;

  // R data FIFO
  logic [c_EW-1:0]       r_mem [DEPTH];
  logic [c_AW-1:0]       r_wptr;
  logic [c_AW-1:0]       r_rptr;
  logic [c_AW:0]         r_cnt;

  logic                  w_fit;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_top_ar_hs;
  logic                  w_bus_ar_hs;
  logic                  w_bus_r_hs;
  logic                  w_top_r_hs;
  logic                  w_rlast_hs;
  logic [c_AW:0]         w_burst_beats;
  logic [c_EW-1:0]       w_head;

  // The incoming burst fits if reserved beats plus its own beats stay within DEPTH
  assign w_fit = ({8'd0, r_rsv} + {{(c_AW + 1){1'b0}}, in_TOP_ARLEN} + c_FW'(1)) <= c_DEPTH_F;

  assign w_fifo_full  = (r_cnt == c_DEPTH_C);
  assign w_fifo_empty = (r_cnt == '0);

  assign out_TOP_ARREADY = clk_en & (~r_ar_valid | in_BUS_ARREADY) & w_fit & (r_outs < c_MAXREQS);
  assign out_BUS_ARVALID = clk_en & r_ar_valid;
  assign out_BUS_ARADDR  = r_ar_addr;
  assign out_BUS_ARLEN   = r_ar_len;
  assign out_BUS_RREADY  = clk_en & ~w_fifo_full;
  assign out_TOP_RVALID  = clk_en & ~w_fifo_empty;

  assign w_head        = r_mem[r_rptr];
  assign out_TOP_RDATA = w_head[DATA_WIDTH-1:0];
  assign out_TOP_RLAST = w_head[DATA_WIDTH];

  assign w_top_ar_hs = in_TOP_ARVALID & out_TOP_ARREADY;
  assign w_bus_ar_hs = out_BUS_ARVALID & in_BUS_ARREADY;
  assign w_bus_r_hs  = in_BUS_RVALID & out_BUS_RREADY;
  assign w_top_r_hs  = out_TOP_RVALID & in_TOP_RREADY;
  assign w_rlast_hs  = w_bus_r_hs & in_BUS_RLAST;

  // ARLEN+1 always fits the counter width when the burst was accepted
  assign w_burst_beats = w_top_ar_hs ? (c_AW + 1)'({1'b0, in_TOP_ARLEN} + 9'd1) : '0;

  // AR register: a new kernel burst loads it, a bus handshake empties it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ar_valid <= 1'b0;
      r_ar_addr  <= '0;
      r_ar_len   <= '0;
    end else if (w_top_ar_hs) begin
      r_ar_valid <= 1'b1;
      r_ar_addr  <= in_TOP_ARADDR;
      r_ar_len   <= in_TOP_ARLEN;
    end else if (w_bus_ar_hs) begin
      r_ar_valid <= 1'b0;
    end
  end

  // Reserved beats grow by the burst size on accept and shrink per beat delivered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsv <= '0;
    end else begin
      r_rsv <= r_rsv + w_burst_beats - {{c_AW{1'b0}}, w_top_r_hs};
    end
  end

  // Outstanding bursts: count up on accept, down when the bus returns RLAST
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outs <= '0;
    end else begin
      case ({w_top_ar_hs, w_rlast_hs})
        2'b10:   r_outs <= r_outs + c_OW'(1);
        2'b01:   r_outs <= r_outs - c_OW'(1);
        default: r_outs <= r_outs;
      endcase
    end
  end

  // FIFO storage: bus beats are written at the write pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_bus_r_hs) begin
      r_mem[r_wptr] <= {in_BUS_RLAST, in_BUS_RDATA};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_bus_r_hs) begin
        r_wptr <= r_wptr + c_AW'(1);
      end
      if (w_top_r_hs) begin
        r_rptr <= r_rptr + c_AW'(1);
      end
      case ({w_bus_r_hs, w_top_r_hs})
        2'b10:   r_cnt <= r_cnt + (c_AW + 1)'(1);
        2'b01:   r_cnt <= r_cnt - (c_AW + 1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_a_io_l3_in_serialize_a_m_axi_read_throttle.sv
`default_nettype none
// ============================================================================
// Module : tb_a_io_l3_in_serialize_a_m_axi_read_throttle
// Brief  : Scoreboard bench for the AXI read throttle. Expected bus AR
//          requests and kernel R beats are queued when stimulus is issued;
//          monitors pop and compare on every output handshake.
// Rev    : 1.0  initial release
// ============================================================================
module tb_a_io_l3_in_serialize_a_m_axi_read_throttle;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic [AW-1:0] in_TOP_ARADDR;
  logic [7:0]    in_TOP_ARLEN;
  logic          in_TOP_ARVALID;
  logic          out_TOP_ARREADY;
  logic [DW-1:0] out_TOP_RDATA;
  logic          out_TOP_RLAST;
  logic          out_TOP_RVALID;
  logic          in_TOP_RREADY;
  logic [AW-1:0] out_BUS_ARADDR;
  logic [7:0]    out_BUS_ARLEN;
  logic          out_BUS_ARVALID;
  logic          in_BUS_ARREADY;
  logic [DW-1:0] in_BUS_RDATA;
  logic          in_BUS_RLAST;
  logic          in_BUS_RVALID;
  logic          out_BUS_RREADY;

  a_io_l3_in_serialize_a_m_axi_read_throttle #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .MAXREQS(4)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .in_TOP_ARADDR(in_TOP_ARADDR), .in_TOP_ARLEN(in_TOP_ARLEN),
    .in_TOP_ARVALID(in_TOP_ARVALID), .out_TOP_ARREADY(out_TOP_ARREADY),
    .out_TOP_RDATA(out_TOP_RDATA), .out_TOP_RLAST(out_TOP_RLAST),
    .out_TOP_RVALID(out_TOP_RVALID), .in_TOP_RREADY(in_TOP_RREADY),
    .out_BUS_ARADDR(out_BUS_ARADDR), .out_BUS_ARLEN(out_BUS_ARLEN),
    .out_BUS_ARVALID(out_BUS_ARVALID), .in_BUS_ARREADY(in_BUS_ARREADY),
    .in_BUS_RDATA(in_BUS_RDATA), .in_BUS_RLAST(in_BUS_RLAST),
    .in_BUS_RVALID(in_BUS_RVALID), .out_BUS_RREADY(out_BUS_RREADY)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int rready_low = 0;

  logic [DW:0]   r_q[$];
  logic [AW+7:0] ar_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: actual=timeout required=handshake", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic top_ar(input logic [AW-1:0] a, input logic [7:0] l);
    bit ok;
    ok = 1'b0;
    in_TOP_ARADDR  = a;
    in_TOP_ARLEN   = l;
    in_TOP_ARVALID = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_TOP_ARREADY) begin
        ar_q.push_back({a, l});
        ok = 1'b1;
        break;
      end
    end
    tick();
    in_TOP_ARVALID = 1'b0;
    if (!ok) timeout("top_ar_accept");
  endtask

  task automatic bus_beat(input logic [DW-1:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    in_BUS_RDATA  = d;
    in_BUS_RLAST  = last;
    in_BUS_RVALID = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_BUS_RREADY) begin
        r_q.push_back({last, d});
        ok = 1'b1;
        break;
      end
    end
    tick();
    in_BUS_RVALID = 1'b0;
    if (!ok) timeout("bus_r_accept");
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && r_q.size() != 0; i++) tick();
    chk(name, r_q.size(), 0);
  endtask

  // R scoreboard monitor
  always @(negedge clk) begin
    if (!reset && out_TOP_RVALID && in_TOP_RREADY) begin
      if (r_q.size() == 0) begin
        timeout("r_unexpected_beat");
      end else begin
        chk("r_beat", {out_TOP_RLAST, out_TOP_RDATA}, r_q.pop_front());
      end
    end
    if (!reset && clk_en && !out_BUS_RREADY) rready_low++;
  end

  // AR scoreboard monitor
  always @(negedge clk) begin
    if (!reset && out_BUS_ARVALID && in_BUS_ARREADY) begin
      if (ar_q.size() == 0) begin
        timeout("ar_unexpected_request");
      end else begin
        chk("bus_ar", {out_BUS_ARADDR, out_BUS_ARLEN}, ar_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; clk_en = 1'b1;
    in_TOP_ARADDR = '0; in_TOP_ARLEN = '0; in_TOP_ARVALID = 1'b0;
    in_TOP_RREADY = 1'b0; in_BUS_ARREADY = 1'b1;
    in_BUS_RDATA = '0; in_BUS_RLAST = 1'b0; in_BUS_RVALID = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_valids", {out_BUS_ARVALID, out_TOP_RVALID}, 2'b00);
    chk("rst_bus_ar", {out_BUS_ARADDR, out_BUS_ARLEN}, 40'h0);
    chk("rst_top_r", {out_TOP_RLAST, out_TOP_RDATA}, 33'h0);
    chk("rst_counters", {dut.r_rsv, dut.r_outs}, 8'h00);
    chk("rst_arready", out_TOP_ARREADY, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // T1: single ARLEN=3 burst
    chk("t1_arvalid_idle", out_BUS_ARVALID, 1'b0);
    top_ar(32'h100, 8'd3);
    chk("t1_arvalid", out_BUS_ARVALID, 1'b1);
    chk("t1_arlen", out_BUS_ARLEN, 8'd3);
    chk("t1_rsv", dut.r_rsv, 5'd4);
    chk("t1_outs", dut.r_outs, 3'd1);
    in_TOP_RREADY = 1'b1;
    for (int k = 0; k < 4; k++) bus_beat(32'hA0 + k, k == 3);
    drain("t1_drain");
    chk("t1_idle", {dut.r_rsv, dut.r_outs}, 8'h00);

    // T2: reservation limit
    in_TOP_RREADY = 1'b0;
    for (int i = 0; i < 4; i++) top_ar(32'h200 + 32'(i * 16), 8'd3);
    for (int k = 0; k < 16; k++) bus_beat(32'h1000 + k, (k % 4) == 3);
    chk("t2_rsv_full", dut.r_rsv, 5'd16);
    chk("t2_outs", dut.r_outs, 3'd0);
    chk("t2_fifo_full", out_BUS_RREADY, 1'b0);
    in_TOP_ARADDR = 32'h2F0; in_TOP_ARLEN = 8'd0; in_TOP_ARVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall", out_TOP_ARREADY, 1'b0);
    end
    tick();
    in_TOP_RREADY = 1'b1;
    @(negedge clk);
    chk("t2_stall_pop_cycle", out_TOP_ARREADY, 1'b0);
    tick();
    in_TOP_RREADY = 1'b0;
    @(negedge clk);
    chk("t2_accept_after_pop", out_TOP_ARREADY, 1'b1);
    if (out_TOP_ARREADY) ar_q.push_back({32'h2F0, 8'd0});
    tick();
    in_TOP_ARVALID = 1'b0;
    chk("t2_rsv_after", dut.r_rsv, 5'd16);
    in_TOP_RREADY = 1'b1;
    bus_beat(32'h1FF, 1'b1);
    drain("t2_drain");
    chk("t2_idle", {dut.r_rsv, dut.r_outs}, 8'h00);

    // T3: outstanding-burst limit
    for (int i = 0; i < 4; i++) top_ar(32'h300 + 32'(i * 4), 8'd0);
    in_TOP_ARADDR = 32'h340; in_TOP_ARLEN = 8'd0; in_TOP_ARVALID = 1'b1;
    @(negedge clk);
    chk("t3_stall_maxreqs", out_TOP_ARREADY, 1'b0);
    tick();
    bus_beat(32'h2000, 1'b1);
    @(negedge clk);
    chk("t3_accept_after_rlast", out_TOP_ARREADY, 1'b1);
    if (out_TOP_ARREADY) ar_q.push_back({32'h340, 8'd0});
    tick();
    in_TOP_ARVALID = 1'b0;
    for (int k = 1; k < 5; k++) bus_beat(32'h2000 + k, 1'b1);
    drain("t3_drain");
    chk("t3_idle", {dut.r_rsv, dut.r_outs}, 8'h00);
    chk("ar_queue_empty", ar_q.size(), 0);

    // T4: 16-beat stream with kernel RREADY toggling
    rready_low = 0;
    top_ar(32'h400, 8'd15);
    fork
      begin
        for (int k = 0; k < 16; k++) bus_beat(32'(k), k == 15);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          tick();
          in_TOP_RREADY = ~in_TOP_RREADY;
        end
      end
    join
    in_TOP_RREADY = 1'b1;
    drain("t4_drain");
    chk("t4_bus_rready_never_low", rready_low, 0);
    chk("t4_idle", {dut.r_rsv, dut.r_outs}, 8'h00);

    // T5: clk_en low mid-burst
    in_TOP_RREADY = 1'b0;
    top_ar(32'h500, 8'd7);
    for (int k = 0; k < 4; k++) bus_beat(32'h5000 + k, 1'b0);
    clk_en = 1'b0;
    in_TOP_ARADDR = 32'h5FF; in_TOP_ARLEN = 8'd0; in_TOP_ARVALID = 1'b1;
    in_BUS_RDATA = 32'hDEAD; in_BUS_RLAST = 1'b1; in_BUS_RVALID = 1'b1;
    in_TOP_RREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_outputs_gated", {out_BUS_ARVALID, out_TOP_ARREADY, out_TOP_RVALID, out_BUS_RREADY}, 4'h0);
    end
    tick();
    clk_en = 1'b1;
    in_TOP_ARVALID = 1'b0; in_BUS_RVALID = 1'b0; in_TOP_RREADY = 1'b0;
    chk("t5_hold", {dut.r_rsv, dut.r_outs, dut.r_cnt}, {5'd8, 3'd1, 5'd4});
    in_TOP_RREADY = 1'b1;
    for (int k = 4; k < 8; k++) bus_beat(32'h5000 + k, k == 7);
    drain("t5_drain");
    chk("t5_idle", {dut.r_rsv, dut.r_outs}, 8'h00);

    // T6: asynchronous reset mid-burst
    in_BUS_ARREADY = 1'b0;
    in_TOP_RREADY  = 1'b0;
    top_ar(32'h600, 8'd3);
    for (int k = 0; k < 2; k++) bus_beat(32'h6000 + k, 1'b0);
    chk("t6_pre_valids", {out_BUS_ARVALID, out_TOP_RVALID}, 2'b11);
    #2 reset = 1'b1;
    r_q.delete();
    ar_q.delete();
    #1;
    chk("t6_valids_drop", {out_BUS_ARVALID, out_TOP_RVALID}, 2'b00);
    chk("t6_counters", {dut.r_rsv, dut.r_outs}, 8'h00);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_arready", out_TOP_ARREADY, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
